// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the execute-stage pipeline control logic.
//   FWD_RF / FWD_W / FWD_M : operand forward-select encodings
//   mc_state_e             : multi-cycle sequencing FSM states
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file
  localparam logic [1:0] FWD_W  = 2'b01;  // ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // ALU_ResultM

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/fwd_select.sv
// Forward-select for one execute-stage source operand.
//   i_rs          : source register of the operand in execute
//   i_rd_m/i_rd_w : destination registers in memory / writeback
//   i_reg_write_m : memory-stage instruction writes the register file
//   i_reg_write_w : writeback-stage instruction writes the register file
//   o_sel         : FWD_M, FWD_W or FWD_RF; memory stage has priority
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_reg_write_m,
  input  logic       i_reg_write_w,
  output logic [1:0] o_sel
);

  logic w_hit_m;
  logic w_hit_w;

  // x0 is hard-wired to zero and never forwarded.
  assign w_hit_m = i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs);
  assign w_hit_w = i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs);

  always_comb begin
    if (w_hit_m) begin
      o_sel = FWD_M;
    end else if (w_hit_w) begin
      o_sel = FWD_W;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/execute_hazard_controller.sv
// Execute-stage hazard and sequencing controller.
//   Inputs : decode/execute source registers, EX/MEM/WB destinations and write
//            enables, load flag (ResultSrcE), taken branch (PCSrcE) and
//            multi-cycle op flag (MultiCycleE).
//   Outputs: ForwardA_E/ForwardB_E operand selects, StallF/D/E, FlushD/E,
//            BubbleM, BusyE, MC_Done and the saturating StallCount.
// A multi-cycle op occupies execute for MC_LAT cycles: a detect cycle in RUN,
// MC_LAT-2 cycles in BUSY, then one DONE cycle in which the result is valid.
module execute_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MultiCycleE,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             BubbleM,
  output logic             BusyE,
  output logic             MC_Done,
  output logic [CNT_W-1:0] StallCount
);

  // BUSY covers MC_LAT-2 cycles, so the down-counter starts at MC_LAT-3.
  localparam logic [3:0] LoadVal = (MC_LAT > 2) ? 4'(MC_LAT - 3) : 4'd0;

  mc_state_e        r_state;
  mc_state_e        w_state_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;
  logic [CNT_W-1:0] r_stall_count;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_lu;

  fwd_select u_fwd_a (
    .i_rs          (Rs1E),
    .i_rd_m        (RD_M),
    .i_rd_w        (RD_W),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_sel         (w_fwd_a)
  );

  fwd_select u_fwd_b (
    .i_rs          (Rs2E),
    .i_rd_m        (RD_M),
    .i_rd_w        (RD_W),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_sel         (w_fwd_b)
  );

  assign w_lu = ResultSrcE && (RD_E != 5'd0) && ((RD_E == Rs1D) || (RD_E == Rs2D));

  always_comb begin
    ForwardA_E   = FWD_RF;
    ForwardB_E   = FWD_RF;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    BubbleM      = 1'b0;
    BusyE        = 1'b0;
    MC_Done      = 1'b0;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!rst) begin
      ForwardA_E = w_fwd_a;
      ForwardB_E = w_fwd_b;
      unique case (r_state)
        RUN, DONE: begin
          if (r_state == RUN && MultiCycleE) begin
            // Detect cycle: hold everything upstream, branch and LU ignored.
            StallF       = 1'b1;
            StallD       = 1'b1;
            StallE       = 1'b1;
            BubbleM      = 1'b1;
            BusyE        = 1'b1;
            w_state_next = (MC_LAT == 2) ? DONE : BUSY;
            w_cnt_next   = LoadVal;
          end else begin
            if (PCSrcE) begin
              FlushD = 1'b1;
              FlushE = 1'b1;
            end else if (w_lu) begin
              StallF = 1'b1;
              StallD = 1'b1;
              FlushE = 1'b1;
            end
            MC_Done      = (r_state == DONE);
            w_state_next = RUN;
          end
        end
        BUSY: begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          BubbleM = 1'b1;
          BusyE   = 1'b1;
          if (r_cnt == 4'd0) begin
            w_state_next = DONE;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
        default: w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_cnt         <= 4'd0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (StallF && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign StallCount = r_stall_count;

endmodule

// File: tb/tb_execute_hazard_controller.sv
// Bench for execute_hazard_controller: four instances sharing one input set
// (MC_LAT 4/2/8/3, the last with a 3-bit counter to reach saturation).
module tb_execute_hazard_controller;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, rse, pcs, mce;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       sf, sd, se, fd, fe, bm, busy, done;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  localparam int NDut = 4;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RD_W;
  logic       RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiCycleE;

  out_t        got     [NDut];
  logic [31:0] cnt_got [NDut];

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    localparam int unsigned L  = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 8 : 3;
    localparam int unsigned CW = (g == 3) ? 3 : 32;
    logic [1:0]    fa, fb;
    logic          sf, sd, se, fd, fe, bm, busy, done;
    logic [CW-1:0] sc;

    execute_hazard_controller #(
      .MC_LAT (L),
      .CNT_W  (CW)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .Rs1D        (Rs1D),
      .Rs2D        (Rs2D),
      .Rs1E        (Rs1E),
      .Rs2E        (Rs2E),
      .RD_E        (RD_E),
      .RD_M        (RD_M),
      .RD_W        (RD_W),
      .RegWriteM   (RegWriteM),
      .RegWriteW   (RegWriteW),
      .ResultSrcE  (ResultSrcE),
      .PCSrcE      (PCSrcE),
      .MultiCycleE (MultiCycleE),
      .ForwardA_E  (fa),
      .ForwardB_E  (fb),
      .StallF      (sf),
      .StallD      (sd),
      .StallE      (se),
      .FlushD      (fd),
      .FlushE      (fe),
      .BubbleM     (bm),
      .BusyE       (busy),
      .MC_Done     (done),
      .StallCount  (sc)
    );

    assign got[g]     = {fa, fb, sf, sd, se, fd, fe, bm, busy, done};
    assign cnt_got[g] = 32'(sc);
  end

  // ---------------- reference model ----------------
  // Tracks how far (1..L) the current multi-cycle op is into its stay in
  // execute; 0 means no op is occupying execute.
  int          lat  [NDut] = '{4, 2, 8, 3};
  logic [31:0] cmax [NDut] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
  int          mpos [NDut];
  logic [31:0] mcnt [NDut];

  function automatic logic [1:0] m_fwd(logic [4:0] rs, in_t x);
    if (x.rwm && x.rdm != 0 && x.rdm == rs) return 2'b10;
    if (x.rww && x.rdw != 0 && x.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int m_eff_pos(in_t x, int p);
    if (x.rst) return 0;
    if (p == 0 && x.mce) return 1;
    return p;
  endfunction

  function automatic out_t m_out(in_t x, int p, int l);
    out_t o = '0;
    logic lu;
    if (x.rst) return o;
    o.fa = m_fwd(x.rs1e, x);
    o.fb = m_fwd(x.rs2e, x);
    lu = x.rse && x.rde != 0 && (x.rde == x.rs1d || x.rde == x.rs2d);
    if (p >= 1 && p < l) begin
      o.sf = 1; o.sd = 1; o.se = 1; o.bm = 1; o.busy = 1;
    end else begin
      if (x.pcs) begin
        o.fd = 1; o.fe = 1;
      end else if (lu) begin
        o.sf = 1; o.sd = 1; o.fe = 1;
      end
      o.done = (p == l);
    end
    return o;
  endfunction

  // ---------------- helpers ----------------
  task automatic drive(in_t x);
    rst = x.rst; Rs1D = x.rs1d; Rs2D = x.rs2d; Rs1E = x.rs1e; Rs2E = x.rs2e;
    RD_E = x.rde; RD_M = x.rdm; RD_W = x.rdw; RegWriteM = x.rwm; RegWriteW = x.rww;
    ResultSrcE = x.rse; PCSrcE = x.pcs; MultiCycleE = x.mce;
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic step(in_t x);
    @(negedge clk);
    drive(x);
    #2;
  endtask

  task automatic chk_out(string name, int d, out_t exp);
    n_chk++;
    if (got[d] !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d outputs got=%h exp=%h", name, d, got[d], exp);
    end
  endtask

  task automatic chk_cnt(string name, int d, logic [31:0] exp);
    n_chk++;
    if (cnt_got[d] !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d StallCount got=%0d exp=%0d", name, d, cnt_got[d], exp);
    end
  endtask

  // ---------------- test ----------------
  vec_t vt[$];

  initial begin
    in_t  x, q, r;
    vec_t v;
    out_t z, s, dn, lu_o, br_o;

    z = '0;
    s = '0; s.sf = 1; s.sd = 1; s.se = 1; s.bm = 1; s.busy = 1;
    dn = '0; dn.done = 1;
    lu_o = '0; lu_o.sf = 1; lu_o.sd = 1; lu_o.fe = 1;
    br_o = '0; br_o.fd = 1; br_o.fe = 1;
    q = '0;
    r = '0; r.rst = 1;

    // Vector table: single-cycle checks, all instances sitting in RUN.
    v.name = "fwd_m_prio"; v.in = q; v.in.rs1e = 5; v.in.rdm = 5; v.in.rdw = 5;
    v.in.rwm = 1; v.in.rww = 1; v.exp = z; v.exp.fa = 2'b10; vt.push_back(v);
    v.name = "fwd_w"; v.in.rwm = 0; v.exp = z; v.exp.fa = 2'b01; vt.push_back(v);
    v.name = "fwd_rs_x0"; v.in = q; v.in.rdm = 5; v.in.rdw = 5; v.in.rwm = 1; v.in.rww = 1;
    v.exp = z; vt.push_back(v);
    v.name = "fwd_rd_x0"; v.in = q; v.in.rwm = 1; v.in.rww = 1; v.exp = z; vt.push_back(v);
    v.name = "fwd_b_m"; v.in = q; v.in.rs2e = 9; v.in.rdm = 9; v.in.rwm = 1;
    v.exp = z; v.exp.fb = 2'b10; vt.push_back(v);
    v.name = "fwd_both"; v.in = q; v.in.rs1e = 3; v.in.rs2e = 4; v.in.rdm = 3; v.in.rdw = 4;
    v.in.rwm = 1; v.in.rww = 1; v.exp = z; v.exp.fa = 2'b10; v.exp.fb = 2'b01; vt.push_back(v);
    v.name = "fwd_w_m_miss"; v.in = q; v.in.rs1e = 6; v.in.rdm = 7; v.in.rdw = 6;
    v.in.rwm = 1; v.in.rww = 1; v.exp = z; v.exp.fa = 2'b01; vt.push_back(v);
    v.name = "lu_rs2"; v.in = q; v.in.rse = 1; v.in.rde = 7; v.in.rs2d = 7;
    v.exp = lu_o; vt.push_back(v);
    v.name = "lu_rs1"; v.in = q; v.in.rse = 1; v.in.rde = 11; v.in.rs1d = 11;
    v.exp = lu_o; vt.push_back(v);
    v.name = "lu_x0"; v.in = q; v.in.rse = 1; v.exp = z; vt.push_back(v);
    v.name = "no_load"; v.in = q; v.in.rde = 7; v.in.rs1d = 7; v.exp = z; vt.push_back(v);
    v.name = "br_over_lu"; v.in = q; v.in.rse = 1; v.in.rde = 7; v.in.rs2d = 7; v.in.pcs = 1;
    v.exp = br_o; vt.push_back(v);
    v.name = "br"; v.in = q; v.in.pcs = 1; v.exp = br_o; vt.push_back(v);

    drive(r);

    // Reset: every output forced low even with all hazards present.
    x = q; x.rst = 1; x.rs1e = 5; x.rdm = 5; x.rwm = 1; x.rse = 1; x.rde = 7; x.rs1d = 7;
    x.pcs = 1; x.mce = 1;
    step(x);
    step(x);
    for (int d = 0; d < NDut; d++) chk_out("reset_outputs", d, z);
    step(q);
    for (int d = 0; d < NDut; d++) begin
      chk_out("post_reset_idle", d, z);
      chk_cnt("post_reset_count", d, 0);
    end

    // Load-use: one bubble cycle, counted once.
    x = q; x.rse = 1; x.rde = 7; x.rs2d = 7;
    step(x);
    for (int d = 0; d < NDut; d++) chk_out("lu_bubble", d, lu_o);
    step(q);
    for (int d = 0; d < NDut; d++) begin
      chk_out("lu_released", d, z);
      chk_cnt("lu_count", d, 1);
    end

    foreach (vt[i]) begin
      step(vt[i].in);
      for (int d = 0; d < NDut; d++) chk_out(vt[i].name, d, vt[i].exp);
    end

    // Multi-cycle op with MultiCycleE held for four cycles.
    step(r);
    x = q; x.mce = 1;
    for (int c = 1; c <= 4; c++) begin
      step(x);
      chk_out("mc4_seq", 0, (c < 4) ? s : dn);
      chk_out("mc2_seq", 1, (c % 2 == 1) ? s : dn);
      chk_out("mc8_seq", 2, s);
    end
    step(q);
    chk_out("mc4_back_run", 0, z);
    chk_out("mc2_back_run", 1, z);
    chk_cnt("mc4_count", 0, 3);
    chk_cnt("mc2_count", 1, 2);

    // Reset in the middle of an 8-cycle op, then a fresh op.
    step(r);
    x = q; x.mce = 1;
    step(x);
    step(x);
    chk_out("mc8_busy", 2, s);
    x.rst = 1; x.rs1e = 5; x.rdm = 5; x.rwm = 1;
    step(x);
    for (int d = 0; d < NDut; d++) chk_out("mid_op_reset", d, z);
    x = q; x.mce = 1;
    for (int c = 1; c <= 8; c++) begin
      step(x);
      if (c == 1) chk_cnt("mc8_count_cleared", 2, 0);
      chk_out("mc8_fresh", 2, (c < 8) ? s : dn);
    end
    step(q);
    chk_out("mc8_back_run", 2, z);
    chk_cnt("mc8_count", 2, 7);

    // Randomised phase against the model; starts with a reset cycle.
    for (int d = 0; d < NDut; d++) begin
      mpos[d] = 0;
      mcnt[d] = 0;
    end
    for (int i = 0; i < 3000; i++) begin
      x.rst  = (i == 0) || ($urandom_range(0, 63) == 0);
      x.rs1d = 5'($urandom_range(0, 3));
      x.rs2d = 5'($urandom_range(0, 3));
      x.rs1e = 5'($urandom_range(0, 3));
      x.rs2e = 5'($urandom_range(0, 3));
      x.rde  = 5'($urandom_range(0, 3));
      x.rdm  = 5'($urandom_range(0, 3));
      x.rdw  = 5'($urandom_range(0, 3));
      x.rwm  = 1'($urandom_range(0, 1));
      x.rww  = 1'($urandom_range(0, 1));
      x.rse  = 1'($urandom_range(0, 1));
      x.pcs  = ($urandom_range(0, 5) == 0);
      x.mce  = ($urandom_range(0, 3) == 0);
      step(x);
      for (int d = 0; d < NDut; d++) begin
        int   p;
        out_t e;
        p = m_eff_pos(x, mpos[d]);
        e = m_out(x, p, lat[d]);
        chk_out("random", d, e);
        if (i != 0) chk_cnt("random_count", d, mcnt[d]);
        if (x.rst) mcnt[d] = 0;
        else if (e.sf && mcnt[d] < cmax[d]) mcnt[d] = mcnt[d] + 1;
        mpos[d] = (p > 0 && p < lat[d]) ? p + 1 : 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_hazard_controller.md
Name: execute_hazard_controller

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline's execute stage.
- Drives the execute-stage operand forwarding selects and the stall/flush/bubble controls for fetch, decode and execute.
- Sequences multi-cycle execute operations (e.g. mul/div) through a small FSM, holding the pipeline until the result is ready.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
MC_LAT, 4, cycles a multi-cycle op occupies execute; legal range 2..16
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
Rs1D  in  5  rs1 of the instruction in decode
Rs2D  in  5  rs2 of the instruction in decode
Rs1E  in  5  rs1 of the instruction in execute
Rs2E  in  5  rs2 of the instruction in execute
RD_E  in  5  destination register in execute
RD_M  in  5  destination register in memory
RD_W  in  5  destination register in writeback
RegWriteM  in  1  memory-stage instruction writes the register file
RegWriteW  in  1  writeback-stage instruction writes the register file
ResultSrcE  in  1  execute-stage instruction is a load
PCSrcE  in  1  branch taken, resolved in execute
MultiCycleE  in  1  execute-stage instruction is a multi-cycle op
ForwardA_E  out  2  srcA select: 00 register file, 01 ResultW, 10 ALU_ResultM
ForwardB_E  out  2  srcB select, same encoding as ForwardA_E
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register
BubbleM  out  1  load a bubble into EX/MEM (control bits zeroed)
BusyE  out  1  multi-cycle op in progress
MC_Done  out  1  final cycle of a multi-cycle op; result must be valid this cycle
StallCount  out  CNT_W  cycles with StallF=1, saturating

Behaviour:
- Clocking and reset:
  - Single clock domain; rst is synchronous and active-high.
  - Reset values: state=RUN, counter=0, StallCount=0.
  - While rst=1, all outputs are forced to 0: ForwardA_E/ForwardB_E=00, all stall/flush/bubble=0, BusyE=0, MC_Done=0.
- Forwarding (combinational, zero latency), per operand X in {1,2}:
  - Select 10 if RegWriteM && RD_M!=0 && RD_M==RsXE.
  - Else select 01 if RegWriteW && RD_W!=0 && RD_W==RsXE.
  - Else select 00.
  - Memory stage has priority over writeback. Forwarding is active in every state.
- Load-use hazard (RUN state only):
  - LU = ResultSrcE && RD_E!=0 && (RD_E==Rs1D || RD_E==Rs2D).
  - LU=1 gives StallF=StallD=1 and FlushE=1 in the same cycle: a one-cycle bubble.
- Taken branch (RUN or DONE state): PCSrcE=1 gives FlushD=FlushE=1 and suppresses the LU stall. The branch has priority.
- Multi-cycle FSM (states RUN, BUSY, DONE):
  - RUN with MultiCycleE=1:
    - Assert StallF, StallD, StallE, BubbleM and BusyE.
    - If MC_LAT==2, go to DONE; else load cnt=MC_LAT-3 and go to BUSY.
    - LU is ignored in this cycle.
  - BUSY:
    - Assert StallF, StallD, StallE, BubbleM and BusyE.
    - If cnt==0, go to DONE; else cnt decrements.
  - DONE:
    - Assert MC_Done; no multi-cycle stall; MultiCycleE is ignored.
    - The instruction leaves execute at the end of the cycle.
    - LU and PCSrcE are evaluated as in RUN.
    - Always return to RUN.
  - Result: the op occupies execute for exactly MC_LAT cycles, and StallF is high for MC_LAT-1 of them.
  - PCSrcE is ignored in BUSY and in the RUN-detect cycle.
- Reset mid-operation: rst=1 in BUSY gives RUN with cnt=0 at the next edge, and no outputs are asserted during reset.
- StallCount:
  - Increments on every cycle with StallF=1 and rst=0.
  - Holds at 2^CNT_W-1; no wrap.
- Invariants: StallE=1 implies StallD=StallF=1. FlushE and StallE are never both 1.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - Forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - The FSM state type {RUN, BUSY, DONE}.
- One natural sub-module, fwd_select: instantiated twice, once per operand; its inputs are RsXE, RD_M, RD_W, RegWriteM and RegWriteW, and its output is the 2-bit select.
- The FSM, hazard logic and counter stay in the top module.

Test Plan:
- Forwarding priority: RD_M=RD_W=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardA_E=10. With RegWriteM=0 -> 01. With Rs1E=0 and both writes set -> 00.
- Load-use: ResultSrcE=1, RD_E=7, Rs2D=7 in RUN -> StallF=StallD=FlushE=1 for exactly 1 cycle, then StallCount=1.
- Branch vs load-use: LU condition and PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=0.
- Multi-cycle, MC_LAT=4: MultiCycleE held high -> StallF/StallD/StallE/BubbleM/BusyE high for cycles 1-3, MC_Done=1 in cycle 4, then RUN; StallCount increases by 3.
- Multi-cycle, MC_LAT=2 -> 1 stall cycle, then DONE, then RUN.
- Reset mid-op: rst=1 during BUSY (MC_LAT=8, cycle 3) -> all outputs 0 while rst=1. Next cycle state=RUN and StallCount=0; with MultiCycleE still high, a fresh 7-cycle stall starts.
